// File: rtl/change_dispenser_seq.sv
// change_dispenser_seq
// Sequential greedy change splitter. A request carries an amount in cents; the
// block takes one coin (or steps to the next denomination) per clock and returns
// per-denomination counts, the undispensable remainder and an exact flag.
// Optional feature macro: CHG_INVENTORY_EN adds per-denomination stock counters
// that limit how many coins of each kind may be taken and are debited on delivery.
module change_dispenser_seq #(
  parameter int AMT_W = 14,
  parameter int CNT_W = 4,
  parameter int DEN0  = 100,
  parameter int DEN1  = 25,
  parameter int DEN2  = 10,
  parameter int DEN3  = 5
`ifdef CHG_INVENTORY_EN
  ,
  parameter int INV_W = 8
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [AMT_W-1:0]   in_amount,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [4*CNT_W-1:0] out_coins,
  output logic [AMT_W-1:0]   out_rem,
  output logic               out_exact,
  output logic               busy
`ifdef CHG_INVENTORY_EN
  ,
  input  logic               inv_wr,
  input  logic [1:0]         inv_sel,
  input  logic [INV_W-1:0]   inv_data,
  output logic [4*INV_W-1:0] inv_level
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Denomination value selected by index, largest first.
  function automatic logic [AMT_W-1:0] den_of(input logic [1:0] i);
    case (i)
      2'd0:    den_of = AMT_W'(DEN0);
      2'd1:    den_of = AMT_W'(DEN1);
      2'd2:    den_of = AMT_W'(DEN2);
      default: den_of = AMT_W'(DEN3);
    endcase
  endfunction

  state_t           state_r, state_nxt_s;
  logic [AMT_W-1:0] rem_r;
  logic [CNT_W-1:0] cnt_r [4];
  logic [1:0]       idx_r;
  logic             exact_r;

  logic [AMT_W-1:0] den_s;
  logic [CNT_W-1:0] cnt_cur_s;
  logic             stock_ok_s;
  logic             can_take_s;
  logic             accept_s;
  logic             take_s;
  logic             step_s;
  logic             release_s;

`ifdef CHG_INVENTORY_EN
  logic [INV_W-1:0] inv_r [4];
`endif

  assign den_s     = den_of(idx_r);
  assign cnt_cur_s = cnt_r[idx_r];
`ifdef CHG_INVENTORY_EN
  assign stock_ok_s = (32'(cnt_cur_s) < 32'(inv_r[idx_r]));
`else
  assign stock_ok_s = 1'b1;
`endif
  assign can_take_s = (rem_r >= den_s) && (cnt_cur_s != CNT_MAX) && stock_ok_s;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode and per-cycle datapath strobes.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    take_s      = 1'b0;
    step_s      = 1'b0;
    release_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          accept_s    = 1'b1;
          state_nxt_s = ST_CALC;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (can_take_s) begin
          take_s = 1'b1;
        end else begin
          step_s = 1'b1;
          if (idx_r == 2'd3) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_CALC;
          end
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          release_s   = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Working remainder, counts and denomination index; they double as the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_r   <= '0;
      idx_r   <= 2'd0;
      exact_r <= 1'b0;
      for (int i = 0; i < 4; i++) cnt_r[i] <= '0;
    end else if (accept_s) begin
      rem_r   <= in_amount;
      idx_r   <= 2'd0;
      exact_r <= 1'b0;
      for (int i = 0; i < 4; i++) cnt_r[i] <= '0;
    end else if (take_s) begin
      rem_r        <= rem_r - den_s;
      cnt_r[idx_r] <= cnt_cur_s + {{(CNT_W-1){1'b0}}, 1'b1};
    end else if (step_s) begin
      idx_r <= idx_r + 2'd1;
      if (idx_r == 2'd3) begin
        exact_r <= (rem_r == '0);
      end
    end
  end

`ifdef CHG_INVENTORY_EN
  // Stock counters: host writes win over the debit applied when a result is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) inv_r[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (inv_wr && (inv_sel == 2'(i))) begin
          inv_r[i] <= inv_data;
        end else if (release_s) begin
          if (32'(inv_r[i]) >= 32'(cnt_r[i])) begin
            inv_r[i] <= inv_r[i] - INV_W'(cnt_r[i]);
          end else begin
            inv_r[i] <= '0;
          end
        end
      end
    end
  end

  assign inv_level = {inv_r[0], inv_r[1], inv_r[2], inv_r[3]};
`endif

  assign in_ready  = (state_r == ST_IDLE);
  assign busy      = (state_r != ST_IDLE);
  assign out_valid = (state_r == ST_DONE);
  assign out_coins = {cnt_r[0], cnt_r[1], cnt_r[2], cnt_r[3]};
  assign out_rem   = rem_r;
  assign out_exact = exact_r;

endmodule

// File: tb/tb_change_dispenser_seq.sv
// Scoreboard bench for change_dispenser_seq: the driver pushes the greedy
// reference result for every accepted request; a monitor pops and compares it
// when the result appears, and checks latency and hold stability.
module tb_change_dispenser_seq;
  localparam int AMT_W = 14;
  localparam int CNT_W = 4;
  localparam int DEN[4] = '{100, 25, 10, 5};

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [AMT_W-1:0]   in_amount = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [4*CNT_W-1:0] out_coins;
  logic [AMT_W-1:0]   out_rem;
  logic               out_exact;
  logic               busy;
`ifdef CHG_INVENTORY_EN
  localparam int INV_W = 8;
  logic               inv_wr = 1'b0;
  logic [1:0]         inv_sel = 2'd0;
  logic [INV_W-1:0]   inv_data = '0;
  logic [4*INV_W-1:0] inv_level;
  int                 model_inv[4] = '{0, 0, 0, 0};
`endif

  typedef struct {
    logic [15:0] coins;
    int          rem;
    bit          exact;
    int          acc;
    int          lat;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  change_dispenser_seq dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_amount(in_amount),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_coins(out_coins), .out_rem(out_rem), .out_exact(out_exact), .busy(busy)
`ifdef CHG_INVENTORY_EN
    , .inv_wr(inv_wr), .inv_sel(inv_sel), .inv_data(inv_data), .inv_level(inv_level)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Greedy split with plain arithmetic: as many of each coin as fit, capped.
  function automatic exp_t model(input int amt);
    exp_t e;
    int rem = amt;
    int tot = 0;
    int n;
    e.coins = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      n = rem / DEN[i];
      if (n > 15) n = 15;
`ifdef CHG_INVENTORY_EN
      if (n > model_inv[i]) n = model_inv[i];
`endif
      rem -= n * DEN[i];
      tot += n;
      e.coins[(3-i)*4 +: 4] = n[3:0];
    end
    e.rem = rem;
    e.exact = (rem == 0);
    e.lat = tot + 4;
    e.acc = 0;
    return e;
  endfunction

  task automatic send(input int amt);
    int t = 0;
    exp_t e;
    @(negedge clk);
    in_valid  = 1'b1;
    in_amount = AMT_W'(amt);
    while (!in_ready && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=busy required=ready amount=%0d", amt);
    end else begin
      #1;
      e = model(amt);
      e.acc = cyc + 1;
      q.push_back(e);
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

`ifdef CHG_INVENTORY_EN
  task automatic inv_write(input int sel, input int data);
    @(negedge clk);
    inv_wr = 1'b1;
    inv_sel = 2'(sel);
    inv_data = INV_W'(data);
    @(negedge clk);
    inv_wr = 1'b0;
    model_inv[sel] = data;
  endtask
`endif

  // Monitor: compare on each rising out_valid, then check hold stability.
  initial begin : monitor
    exp_t        e;
    bit          prev = 1'b0;
    logic [15:0] s_coins = 16'h0000;
    logic [AMT_W-1:0] s_rem = '0;
    logic        s_exact = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete();
        prev = 1'b0;
      end else begin
`ifdef CHG_INVENTORY_EN
        if (prev && !out_valid) begin
          for (int i = 0; i < 4; i++) model_inv[i] -= int'(s_coins[(3-i)*4 +: 4]);
        end
`endif
        if (out_valid) begin
          check("in_ready_in_done", 64'(in_ready), 64'd0);
          if (!prev) begin
            if (q.size() == 0) begin
              checks++;
              failures++;
              $display("FAIL unexpected_output actual=valid required=idle");
            end else begin
              e = q.pop_front();
              check("coins", 64'(out_coins), 64'(e.coins));
              check("rem", 64'(out_rem), 64'(e.rem));
              check("exact", 64'(out_exact), 64'(e.exact));
              check("latency", 64'(cyc - e.acc), 64'(e.lat));
              s_coins = e.coins;
              s_rem   = AMT_W'(e.rem);
              s_exact = e.exact;
            end
          end else begin
            check("hold_coins", 64'(out_coins), 64'(s_coins));
            check("hold_rem", 64'(out_rem), 64'(s_rem));
            check("hold_exact", 64'(out_exact), 64'(s_exact));
          end
        end
        prev = out_valid;
      end
    end
  end

  // Consumer: random back-pressure, with a 10-cycle stall on the fifth result.
  initial begin : consumer
    bit rprev = 1'b0;
    int nval = 0;
    int hold = 0;
    forever begin
      @(negedge clk);
      if (out_valid && !rprev) nval++;
      rprev = out_valid;
      if (nval == 5 && hold < 10 && out_valid) begin
        out_ready = 1'b0;
        hold++;
      end else begin
        out_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  initial begin : driver
    int t;
    #12;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_coins", 64'(out_coins), 64'd0);
    check("rst_rem", 64'(out_rem), 64'd0);
    check("rst_exact", 64'(out_exact), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
`ifdef CHG_INVENTORY_EN
    for (int i = 0; i < 4; i++) inv_write(i, 255);
`endif
    send(0);
    send(185);
    send(187);
    send(2000);
    send(185);
    send(1234);
    // Abort a long computation with an asynchronous reset.
    send(2000);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_in_ready", 64'(in_ready), 64'd1);
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_coins", 64'(out_coins), 64'd0);
    check("abort_rem", 64'(out_rem), 64'd0);
    check("abort_exact", 64'(out_exact), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
`ifdef CHG_INVENTORY_EN
    for (int i = 0; i < 4; i++) model_inv[i] = 0;
    inv_write(0, 0);
    inv_write(1, 10);
    inv_write(2, 255);
    inv_write(3, 255);
    send(100);
    t = 0;
    while ((q.size() != 0 || busy) && t < 500) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    check("inv1_after", 64'(inv_level[16 +: 8]), 64'd6);
    for (int i = 0; i < 4; i++) inv_write(i, 255);
`endif
    for (int k = 0; k < 30; k++) send(int'($urandom_range(0, 2500)));
    t = 0;
    while ((q.size() != 0 || busy) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (q.size() != 0 || busy) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=pending required=empty");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
